// File: rtl/instr_fetch_ctrl_if.sv
// Consumer-side handshake bundle for the instruction fetch controller.
// The master drives the queue head (valid/instr/pc) and the slave returns ready.
interface instr_fetch_ctrl_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks a word-aligned fetch PC through a
// combinational instruction memory and buffers {pc, instr} pairs in a small
// prefetch queue drained by a valid/ready consumer. Redirects flush the queue.
// Optional macro IFC_BOUNDS_CHECK_EN: out-of-range fetches halt the fetcher and
// raise fault; without it, addresses wrap modulo MEM_SIZE and fault is tied 0.
module instr_fetch_ctrl #(
  parameter int DEPTH    = 4,
  parameter int MEM_SIZE = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [63:0]               imem_addr,
  input  logic [31:0]               imem_instr,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  instr_fetch_ctrl_if.master        outIf,
  output logic                      fault
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {RUN, HALT} state_e;

  state_e             state_q, state_d;
  logic [63:0]        fetchPc_q;
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic [63:0]        pcMem_q    [DEPTH];
  logic [31:0]        instrMem_q [DEPTH];

  logic               outValidW;
  logic               popW;
  logic               pushW;
  logic               oobW;
  logic [63:0]        nextSeqPcW;
  logic [63:0]        redirPcW;

`ifdef IFC_BOUNDS_CHECK_EN
  // The last legal word starts at MEM_SIZE-4; anything past it is a fault.
  assign oobW       = (fetchPc_q + 64'd3) >= 64'(MEM_SIZE);
  assign nextSeqPcW = fetchPc_q + 64'd4;
  assign redirPcW   = redirect_pc & ~64'd3;
`else
  localparam logic [63:0] ADDR_MASK = 64'(MEM_SIZE - 1);
  // Without bounds checking the address space simply wraps around memory.
  assign oobW       = 1'b0;
  assign nextSeqPcW = (fetchPc_q + 64'd4) & ADDR_MASK;
  assign redirPcW   = redirect_pc & ~64'd3 & ADDR_MASK;
`endif

  assign imem_addr = fetchPc_q;

  // A redirect hides the head for its cycle so a stale instruction is never consumed.
  assign outValidW = (count_q != '0) && !redirect_valid;
  assign popW      = outValidW && outIf.out_ready;
  assign pushW     = !redirect_valid && (state_q == RUN) && !oobW &&
                     ((count_q < CNT_W'(DEPTH)) || popW);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM next state: an out-of-range fetch parks the fetcher until a redirect.
  always_comb begin
    state_d = state_q;
    if (redirect_valid)                state_d = RUN;
    else if ((state_q == RUN) && oobW) state_d = HALT;
  end

  // FSM outputs: head of queue to the consumer plus the halt fault flag.
  always_comb begin
    outIf.out_valid = outValidW;
    outIf.out_instr = instrMem_q[head_q];
    outIf.out_pc    = pcMem_q[head_q];
`ifdef IFC_BOUNDS_CHECK_EN
    fault = (state_q == HALT);
`else
    fault = 1'b0;
`endif
  end

  // Fetch PC, queue pointers and occupancy; redirect flushes, reset wins over all.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else if (redirect_valid) begin
      fetchPc_q <= redirPcW;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      if (pushW) begin
        fetchPc_q <= nextSeqPcW;
        tail_q    <= tail_q + PTR_W'(1);
      end
      if (popW) head_q <= head_q + PTR_W'(1);
      case ({pushW, popW})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage needs no reset; the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (pushW) begin
      pcMem_q[tail_q]    <= fetchPc_q;
      instrMem_q[tail_q] <= imem_instr;
    end
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-002 SHALL have parameter MEM_SIZE, default 1024, instruction memory size in bytes (power of two, >4).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  64  byte address driven to the combinational instruction memory.
REQ-006 SHALL have port imem_instr  input  32  instruction word returned in the same cycle for imem_addr.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  input  64  redirect target byte address.
REQ-009 SHALL have port out_valid  output  1  queue head holds a valid instruction.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the head this cycle.
REQ-011 SHALL have port out_instr  output  32  head instruction word.
REQ-012 SHALL have port out_pc  output  64  byte address of the head instruction.
REQ-013 SHALL have port fault  output  1  out-of-bounds fetch flag (driven 0 when IFC_BOUNDS_CHECK_EN is undefined).

Function
REQ-014 SHALL hold fetch_pc (64 bit) and drive imem_addr = fetch_pc combinationally.
REQ-015 SHALL keep fetch_pc word-aligned at all times; redirect_pc[1:0] ignored (forced 0).
REQ-016 SHALL implement a FIFO of DEPTH entries {pc, instr}, with count 0..DEPTH and wrapping head/tail pointers.
REQ-017 SHALL assert out_valid = (count != 0) && !redirect_valid; out_instr/out_pc show the head entry.
REQ-018 SHALL pop when out_valid && out_ready.
REQ-019 SHALL push {fetch_pc, imem_instr} and advance fetch_pc by 4 in a cycle when in RUN and (count < DEPTH or a pop occurs that cycle).
REQ-020 SHALL support simultaneous push and pop when full or non-empty, leaving count unchanged.
REQ-021 SHALL give redirect_valid priority: that cycle no push, no pop; next edge queue empties (count=0, pointers reset), fetch_pc <= redirect_pc aligned, state <= RUN.
REQ-022 SHALL show zero fetch latency: an instruction pushed at edge N appears at head with out_valid high from cycle N+1 if the queue was empty.
REQ-023 SHALL implement states RUN and HALT; RUN->HALT per REQ-029; HALT->RUN only on redirect_valid or reset.
REQ-024 SHALL continue draining queued entries to the consumer while in HALT.

Reset
REQ-025 SHALL, on reset high at an edge, set fetch_pc=0, count=0, head=tail=0, state=RUN, fault=0, regardless of in-flight redirect or handshake.
REQ-026 SHALL drive out_valid=0 in the cycle after reset and SHALL push address 0 on the first edge after reset deasserts.
REQ-027 SHALL give reset priority over redirect_valid.

Configuration
REQ-028 SHALL use macro IFC_BOUNDS_CHECK_EN to select bounds handling.
REQ-029 With IFC_BOUNDS_CHECK_EN defined, SHALL treat fetch_pc+3 >= MEM_SIZE as out of bounds: no push, state->HALT, fault=1 from next edge until redirect or reset; an out-of-bounds redirect_pc enters HALT one cycle later.
REQ-030 Without IFC_BOUNDS_CHECK_EN, SHALL compute fetch_pc increments and redirects modulo MEM_SIZE (MEM_SIZE-4 advances to 0), never enter HALT, and tie fault=0.

Verification
REQ-031 Reset then out_ready=1 for 4 cycles -> out_pc 0,4,8,12 on consecutive cycles, out_instr = mem[0..3].
REQ-032 out_ready=0 for 6 cycles after reset -> count saturates at 4, fetch_pc=16, imem_addr held at 16; out_ready=1 -> 0,4,8,12,16 delivered with no gaps.
REQ-033 Queue full, redirect_valid=1 with redirect_pc=0x42 -> out_valid=0 that cycle, next cycle queue empty, fetch_pc=0x40, then out_pc=0x40.
REQ-034 With macro, redirect_pc=0x3F8 -> entries 0x3F8, 0x3FC delivered, then fault=1, out_valid=0 after drain; redirect to 0 clears fault.
REQ-035 Without macro, same stimulus -> 0x3F8, 0x3FC, 0x000 delivered, fault stays 0.
REQ-036 reset asserted mid-stream with redirect_valid=1 -> next cycle fetch_pc=0, count=0, out_valid=0, fault=0.
